// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - frame-aligned start/game/end screen sequencer with 16-level fade
`timescale 1ns/1ps
module screen_sequencer #(
    parameter int FADE_FRAMES_PER_STEP = 1,
    parameter int END_HOLD_FRAMES      = 120
) (
    input  logic       clk40,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       start,
    input  logic       restart,
    input  logic       end_game,
    output logic [1:0] screen_sel,
    output logic [3:0] fade,
    output logic       game_hold,
    output logic       frame_tick,
    output logic       busy
);
    typedef enum logic [2:0] {
        S_START    = 3'd0,
        S_GAME     = 3'd1,
        S_END      = 3'd2,
        S_FADE_OUT = 3'd3,
        S_FADE_IN  = 3'd4
    } state_t;

    localparam logic [3:0] STEP_LAST = 4'(FADE_FRAMES_PER_STEP - 1);
    localparam logic [7:0] HOLD_MAX  = 8'(END_HOLD_FRAMES);

    state_t     state, state_n, target, target_n;
    logic       vblnk_d, frame_edge, step_edge, restart_ok;
    logic       start_p, start_p_n, end_p, end_p_n, restart_p, restart_p_n;
    logic [3:0] step_cnt, step_cnt_n, fade_n;
    logic [7:0] hold_cnt, hold_cnt_n;
    logic [1:0] sel_n;

    function automatic logic [1:0] sel_of(input state_t s);
        case (s)
            S_GAME:  sel_of = 2'b01;
            S_END:   sel_of = 2'b11;
            default: sel_of = 2'b00;
        endcase
    endfunction

    assign frame_edge = vblnk & ~vblnk_d;
    assign step_edge  = frame_edge && (step_cnt == STEP_LAST);
    assign restart_ok = (hold_cnt == HOLD_MAX);

    always_comb begin
        state_n     = state;
        target_n    = target;
        sel_n       = screen_sel;
        fade_n      = fade;
        start_p_n   = 1'b0;
        end_p_n     = 1'b0;
        restart_p_n = 1'b0;
        step_cnt_n  = 4'd0;
        hold_cnt_n  = 8'd0;
        case (state)
            S_START: begin
                // An edge consumes the pending flag but keeps a request arriving in that same cycle
                start_p_n = frame_edge ? start : (start_p | start);
                if (frame_edge && start_p) begin
                    target_n = S_GAME;
                    state_n  = S_FADE_OUT;
                end
            end
            S_GAME: begin
                end_p_n = frame_edge ? end_game : (end_p | end_game);
                if (frame_edge && end_p) begin
                    target_n = S_END;
                    state_n  = S_FADE_OUT;
                end
            end
            S_END: begin
                restart_p_n = frame_edge ? (restart & restart_ok)
                                         : (restart_p | (restart & restart_ok));
                hold_cnt_n  = hold_cnt;
                if (frame_edge) begin
                    if (!restart_ok)
                        hold_cnt_n = hold_cnt + 8'd1;
                    if (restart_p) begin
                        target_n = S_START;
                        state_n  = S_FADE_OUT;
                    end
                end
            end
            S_FADE_OUT: begin
                step_cnt_n = step_cnt;
                if (frame_edge)
                    step_cnt_n = step_edge ? 4'd0 : step_cnt + 4'd1;
                if (step_edge) begin
                    if (fade == 4'd0) begin
                        sel_n   = sel_of(target);
                        state_n = S_FADE_IN;
                    end else begin
                        fade_n = fade - 4'd1;
                    end
                end
            end
            S_FADE_IN: begin
                step_cnt_n = step_cnt;
                if (frame_edge)
                    step_cnt_n = step_edge ? 4'd0 : step_cnt + 4'd1;
                if (step_edge) begin
                    fade_n = (fade == 4'hF) ? 4'hF : fade + 4'd1;
                    if (fade_n == 4'hF)
                        state_n = target;
                end
            end
            default: begin
                state_n  = S_START;
                target_n = S_START;
                sel_n    = 2'b00;
                fade_n   = 4'hF;
            end
        endcase
    end

    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            state      <= S_START;
            target     <= S_START;
            vblnk_d    <= 1'b1;
            start_p    <= 1'b0;
            end_p      <= 1'b0;
            restart_p  <= 1'b0;
            step_cnt   <= 4'd0;
            hold_cnt   <= 8'd0;
            screen_sel <= 2'b00;
            fade       <= 4'hF;
            game_hold  <= 1'b1;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            target     <= target_n;
            vblnk_d    <= vblnk;
            start_p    <= start_p_n;
            end_p      <= end_p_n;
            restart_p  <= restart_p_n;
            step_cnt   <= step_cnt_n;
            hold_cnt   <= hold_cnt_n;
            screen_sel <= sel_n;
            fade       <= fade_n;
            game_hold  <= (state_n != S_GAME);
            frame_tick <= frame_edge;
            busy       <= (state_n == S_FADE_OUT) || (state_n == S_FADE_IN);
        end
    end
endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - scoreboard bench for screen_sequencer
`timescale 1ns/1ps
module tb_screen_sequencer;
    logic       clk40 = 1'b0;
    logic       rst = 1'b1, vblnk = 1'b1, start = 1'b0, restart = 1'b0, end_game = 1'b0;
    logic [1:0] sel_a, sel_b;
    logic [3:0] fade_a, fade_b;
    logic       hold_a, hold_b, tick_a, tick_b, busy_a, busy_b;

    typedef struct packed {
        logic       tick;
        logic [1:0] sel;
        logic [3:0] fade;
        logic       hold;
        logic       busy;
    } frame_t;

    frame_t sb[$];
    frame_t obs_a, obs_b, ex;
    int     n_vec = 0, n_err = 0;

    always #12 clk40 = ~clk40;

    screen_sequencer #(.FADE_FRAMES_PER_STEP(1), .END_HOLD_FRAMES(4)) dut (
        .clk40(clk40), .rst(rst), .vblnk(vblnk), .start(start), .restart(restart),
        .end_game(end_game), .screen_sel(sel_a), .fade(fade_a), .game_hold(hold_a),
        .frame_tick(tick_a), .busy(busy_a));

    screen_sequencer #(.FADE_FRAMES_PER_STEP(3), .END_HOLD_FRAMES(4)) dut3 (
        .clk40(clk40), .rst(rst), .vblnk(vblnk), .start(start), .restart(restart),
        .end_game(end_game), .screen_sel(sel_b), .fade(fade_b), .game_hold(hold_b),
        .frame_tick(tick_b), .busy(busy_b));

    function automatic frame_t mk(input logic [1:0] s, input logic [3:0] f, input logic h, input logic b);
        mk = {1'b1, s, f, h, b};
    endfunction

    // Expected per-edge outputs of a full transition, from the fade timeline
    task automatic push_tr(input logic [1:0] old_sel, input logic [1:0] new_sel,
                           input logic hold_end, input int step);
        for (int k = 1; k <= 1 + 31 * step; k++) begin
            int j;
            logic [3:0] f;
            j = (k - 1) / step;
            if (j <= 15)      f = 4'(15 - j);
            else if (j == 16) f = 4'd0;
            else              f = 4'(j - 16);
            sb.push_back(mk((j >= 16) ? new_sel : old_sel, f,
                            (j == 31) ? hold_end : 1'b1, (j < 31)));
        end
    endtask

    task automatic run_frame(input logic s, input logic r, input logic e);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk40);
            vblnk    = 1'b0;
            start    = (i == 2) & s;
            restart  = (i == 2) & r;
            end_game = (i == 2) & e;
        end
        @(negedge clk40);
        start = 1'b0; restart = 1'b0; end_game = 1'b0;
        vblnk = 1'b1;
        @(negedge clk40);
        obs_a = {tick_a, sel_a, fade_a, hold_a, busy_a};
        obs_b = {tick_b, sel_b, fade_b, hold_b, busy_b};
        @(negedge clk40);
    endtask

    task automatic do_reset();
        rst = 1'b1; vblnk = 1'b1;
        start = 1'b0; restart = 1'b0; end_game = 1'b0;
        repeat (2) @(negedge clk40);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vblnk = 1'b1;
        repeat (3) @(negedge clk40);
        n_vec++;
        if ({tick_a, sel_a, fade_a, hold_a, busy_a} !== 9'b0_00_1111_1_0) begin
            n_err++;
            $display("FAIL reset_values got %b required 000111110", {tick_a, sel_a, fade_a, hold_a, busy_a});
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk40);
            n_vec++;
            if (tick_a !== 1'b0 || busy_a !== 1'b0 || fade_a !== 4'hF) begin
                n_err++;
                $display("FAIL no_spurious_edge cycle=%0d got tick=%b busy=%b fade=%0d required 0/0/15", i, tick_a, busy_a, fade_a);
            end
        end
        sb.push_back(mk(2'b00, 4'hF, 1'b1, 1'b0));
        run_frame(1'b0, 1'b0, 1'b0);
        ex = sb.pop_front();
        n_vec++;
        if (obs_a !== ex) begin
            n_err++;
            $display("FAIL idle_frame got %b required %b", obs_a, ex);
        end
    endtask

    task automatic test_start();
        push_tr(2'b00, 2'b01, 1'b0, 1);
        sb.push_back(mk(2'b01, 4'hF, 1'b0, 1'b0));
        for (int k = 1; sb.size() > 0; k++) begin
            run_frame(k == 1, 1'b0, 1'b0);
            ex = sb.pop_front();
            n_vec++;
            if (obs_a !== ex) begin
                n_err++;
                $display("FAIL start_seq edge=%0d got %b required %b", k, obs_a, ex);
            end
        end
    endtask

    task automatic test_end_game();
        push_tr(2'b01, 2'b11, 1'b1, 1);
        for (int k = 1; sb.size() > 0; k++) begin
            run_frame(1'b0, 1'b0, k == 1);
            ex = sb.pop_front();
            n_vec++;
            if (obs_a !== ex) begin
                n_err++;
                $display("FAIL end_seq edge=%0d got %b required %b", k, obs_a, ex);
            end
        end
    endtask

    task automatic test_restart_hold();
        for (int i = 0; i < 4; i++) sb.push_back(mk(2'b11, 4'hF, 1'b1, 1'b0));
        push_tr(2'b11, 2'b00, 1'b1, 1);
        for (int k = 0; sb.size() > 0; k++) begin
            run_frame(1'b0, (k == 2) || (k == 4), 1'b0);
            ex = sb.pop_front();
            n_vec++;
            if (obs_a !== ex) begin
                n_err++;
                $display("FAIL restart_hold frame=%0d got %b required %b", k, obs_a, ex);
            end
        end
    endtask

    task automatic test_drop_in_fade();
        sb.push_back(mk(2'b00, 4'hF, 1'b1, 1'b0));
        push_tr(2'b00, 2'b01, 1'b0, 1);
        for (int i = 0; i < 3; i++) sb.push_back(mk(2'b01, 4'hF, 1'b0, 1'b0));
        for (int k = 0; sb.size() > 0; k++) begin
            run_frame((k == 1) || (k == 10) || (k == 20), (k <= 1), (k == 0) || (k == 25) || (k == 32));
            ex = sb.pop_front();
            n_vec++;
            if (obs_a !== ex) begin
                n_err++;
                $display("FAIL drop_in_fade frame=%0d got %b required %b", k, obs_a, ex);
            end
        end
    endtask

    task automatic test_fade_step3();
        do_reset();
        push_tr(2'b00, 2'b01, 1'b0, 3);
        for (int k = 1; sb.size() > 0; k++) begin
            run_frame(k == 1, 1'b0, 1'b0);
            ex = sb.pop_front();
            n_vec++;
            if (obs_b !== ex) begin
                n_err++;
                $display("FAIL fade_step3 edge=%0d got %b required %b", k, obs_b, ex);
            end
        end
    endtask

    task automatic test_reset_mid_fade();
        do_reset();
        push_tr(2'b00, 2'b01, 1'b0, 1);
        for (int k = 1; k <= 9; k++) begin
            run_frame(k == 1, 1'b0, 1'b0);
            ex = sb.pop_front();
            n_vec++;
            if (obs_a !== ex) begin
                n_err++;
                $display("FAIL pre_reset edge=%0d got %b required %b", k, obs_a, ex);
            end
        end
        sb.delete();
        @(negedge clk40);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({tick_a, sel_a, fade_a, hold_a, busy_a} !== 9'b0_00_1111_1_0) begin
            n_err++;
            $display("FAIL async_reset got %b required 000111110", {tick_a, sel_a, fade_a, hold_a, busy_a});
        end
        @(negedge clk40);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_end_game();
        test_restart_hold();
        test_drop_in_fade();
        test_fade_step3();
        test_reset_mid_fade();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
